// File: rtl/led_vu_meter.sv
// Stereo VU/peak meter for the 8 board LEDs: instant-attack envelope with exponential
// decay, 6 dB per LED bar and a peak-hold dot that steps down after a hold period.
module led_vu_meter #(
  parameter int unsigned DECAY_SAMPLES = 48,
  parameter int unsigned DECAY_SHIFT   = 4,
  parameter int unsigned PEAK_HOLD     = 24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [7:0]  LED
);

  localparam int unsigned DcntWidth = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
  localparam int unsigned HcntWidth = (PEAK_HOLD > 1) ? $clog2(PEAK_HOLD) : 1;
  localparam logic [DcntWidth-1:0] DcntLast = DcntWidth'(DECAY_SAMPLES - 1);
  localparam logic [HcntWidth-1:0] HcntLast = HcntWidth'(PEAK_HOLD - 1);

  logic [14:0]          env_q, env_d;
  logic [DcntWidth-1:0] decay_cnt_q, decay_cnt_d;
  logic [HcntWidth-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]           peak_lvl_q, peak_lvl_d;
  logic                 v_d1_q;
  logic [7:0]           led_q, led_d;

  logic [14:0] mag_l, mag_r, mag;
  logic [14:0] decay_step;
  logic [3:0]  lvl;
  logic [7:0]  bar, dot;

  // |x| with -32768 clamped so the result always fits 15 bits.
  function automatic logic [14:0] abs_sat(input logic [15:0] x);
    logic [14:0] neg;
    neg = ~x[14:0] + 15'd1;
    if (!x[15]) begin
      return x[14:0];
    end else if (x[14:0] == 15'd0) begin
      return 15'h7FFF;
    end else begin
      return neg;
    end
  endfunction

  always_comb begin
    mag_l = abs_sat(lft_out);
    mag_r = abs_sat(rht_out);
    mag   = (mag_l > mag_r) ? mag_l : mag_r;
  end

  // Small envelopes would otherwise stall at env>>SHIFT == 0.
  always_comb begin
    decay_step = env_q >> DECAY_SHIFT;
    if (decay_step == 15'd0) begin
      decay_step = 15'd1;
    end
  end

  always_comb begin
    env_d       = env_q;
    decay_cnt_d = decay_cnt_q;
    if (valid) begin
      if (mag > env_q) begin
        env_d = mag;
      end else if ((decay_cnt_q == DcntLast) && (env_q != 15'd0)) begin
        env_d = env_q - decay_step;
      end
      decay_cnt_d = (decay_cnt_q == DcntLast) ? '0 : decay_cnt_q + 1'b1;
    end
  end

  // One LED per 6 dB, starting at 128 full-scale counts.
  always_comb begin
    lvl = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (env_q >= (15'd1 << (7 + k))) begin
        lvl = lvl + 4'd1;
      end
    end
  end

  always_comb begin
    peak_lvl_d = peak_lvl_q;
    hold_cnt_d = hold_cnt_q;
    led_d      = led_q;
    bar        = 8'hFF >> (4'd8 - lvl);
    dot        = 8'h00;
    if (v_d1_q) begin
      if (lvl >= peak_lvl_q) begin
        peak_lvl_d = lvl;
        hold_cnt_d = '0;
      end else if (hold_cnt_q == HcntLast) begin
        peak_lvl_d = peak_lvl_q - 4'd1;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if (peak_lvl_d != 4'd0) begin
        dot = 8'd1 << (peak_lvl_d - 4'd1);
      end
      led_d = bar | dot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q       <= '0;
      decay_cnt_q <= '0;
      hold_cnt_q  <= '0;
      peak_lvl_q  <= '0;
      v_d1_q      <= 1'b0;
      led_q       <= 8'h00;
    end else begin
      env_q       <= env_d;
      decay_cnt_q <= decay_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      peak_lvl_q  <= peak_lvl_d;
      v_d1_q      <= valid;
      led_q       <= led_d;
    end
  end

  assign LED = led_q;

endmodule
